// File: rtl/datapath_harness_if.sv
// Host-side request/response bundle for datapath_harness.
// The master drives operand requests and accepts results; the slave is the harness.
interface datapath_harness_if #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 32
);
  logic                        req_valid;
  logic                        req_ready;
  logic signed [IN_WIDTH-1:0]  req_a;
  logic signed [IN_WIDTH-1:0]  req_b;
  logic signed [IN_WIDTH-1:0]  req_c;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic signed [OUT_WIDTH-1:0] rsp_z;
  logic signed [OUT_WIDTH-1:0] rsp_x;

  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_x
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_x
  );
endinterface

// File: rtl/datapath_harness.sv
// Single-transaction wrapper around a registered datapath: holds operands on the
// circuit inputs, waits out its pipeline latency, then returns the captured results.
module datapath_harness #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 32,
  parameter int LATENCY   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  datapath_harness_if.slave           host,
  output logic signed [IN_WIDTH-1:0]  dut_a,
  output logic signed [IN_WIDTH-1:0]  dut_b,
  output logic signed [IN_WIDTH-1:0]  dut_c,
  input  logic signed [OUT_WIDTH-1:0] dut_z,
  input  logic signed [OUT_WIDTH-1:0] dut_x,
  output logic                        busy,
  output logic [15:0]                 txn_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [3:0]                  wait_cnt_q, wait_cnt_d;
  logic signed [IN_WIDTH-1:0]  dut_a_q, dut_a_d;
  logic signed [IN_WIDTH-1:0]  dut_b_q, dut_b_d;
  logic signed [IN_WIDTH-1:0]  dut_c_q, dut_c_d;
  logic signed [OUT_WIDTH-1:0] rsp_z_q, rsp_z_d;
  logic signed [OUT_WIDTH-1:0] rsp_x_q, rsp_x_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        req_ready_q, req_ready_d;
  logic                        busy_q, busy_d;
  logic [15:0]                 txn_count_q, txn_count_d;

  // Next-state and datapath capture; handshake flags are decoded from the next state
  // so req_ready/busy come straight from flops.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    dut_a_d     = dut_a_q;
    dut_b_d     = dut_b_q;
    dut_c_d     = dut_c_q;
    rsp_z_d     = rsp_z_q;
    rsp_x_d     = rsp_x_q;
    rsp_valid_d = rsp_valid_q;
    txn_count_d = txn_count_q;

    case (state_q)
      ST_IDLE: begin
        if (host.req_valid && req_ready_q) begin
          dut_a_d    = host.req_a;
          dut_b_d    = host.req_b;
          dut_c_d    = host.req_c;
          wait_cnt_d = 4'(LATENCY);
          state_d    = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          rsp_z_d     = dut_z;
          rsp_x_d     = dut_x;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && host.rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_count_d = txn_count_q + 16'd1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        wait_cnt_d  = 4'd0;
        state_d     = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State register; reset also abandons any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 4'd0;
      dut_a_q     <= '0;
      dut_b_q     <= '0;
      dut_c_q     <= '0;
      rsp_z_q     <= '0;
      rsp_x_q     <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      txn_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      dut_a_q     <= dut_a_d;
      dut_b_q     <= dut_b_d;
      dut_c_q     <= dut_c_d;
      rsp_z_q     <= rsp_z_d;
      rsp_x_q     <= rsp_x_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign host.req_ready = req_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_z     = rsp_z_q;
  assign host.rsp_x     = rsp_x_q;
  assign dut_a          = dut_a_q;
  assign dut_b          = dut_b_q;
  assign dut_c          = dut_c_q;
  assign busy           = busy_q;
  assign txn_count      = txn_count_q;

endmodule

// File: tb/tb_datapath_harness.sv
// Directed bench: harness u1 drives a 2-stage model circuit (LATENCY=2),
// harness u2 drives a 1-stage model (LATENCY=1) for wrap and back-to-back timing.
module tb_datapath_harness;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  datapath_harness_if #(.IN_WIDTH(64), .OUT_WIDTH(32)) hif1 ();
  datapath_harness_if #(.IN_WIDTH(64), .OUT_WIDTH(32)) hif2 ();

  logic signed [63:0] dut_a1, dut_b1, dut_c1, dut_a2, dut_b2, dut_c2;
  logic signed [31:0] z1, x1, s1_z, s1_x, z2, x2;
  logic               busy1, busy2;
  logic [15:0]        txn1, txn2;

  datapath_harness #(.IN_WIDTH(64), .OUT_WIDTH(32), .LATENCY(2)) u1 (
    .clk(clk), .rst(rst), .host(hif1.slave),
    .dut_a(dut_a1), .dut_b(dut_b1), .dut_c(dut_c1),
    .dut_z(z1), .dut_x(x1), .busy(busy1), .txn_count(txn1)
  );

  datapath_harness #(.IN_WIDTH(64), .OUT_WIDTH(32), .LATENCY(1)) u2 (
    .clk(clk), .rst(rst), .host(hif2.slave),
    .dut_a(dut_a2), .dut_b(dut_b2), .dut_c(dut_c2),
    .dut_z(z2), .dut_x(x2), .busy(busy2), .txn_count(txn2)
  );

  // Model circuits: z = a[31:0]+b[31:0], x = c[31:0], registered 2 and 1 times.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_z <= '0; s1_x <= '0; z1 <= '0; x1 <= '0; z2 <= '0; x2 <= '0;
    end else begin
      s1_z <= dut_a1[31:0] + dut_b1[31:0];
      s1_x <= dut_c1[31:0];
      z1   <= s1_z;
      x1   <= s1_x;
      z2   <= dut_a2[31:0] + dut_b2[31:0];
      x2   <= dut_c2[31:0];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          acc_cyc [2];
  int          n_acc;
  logic [15:0] cnt_at [16];
  logic        rv_at  [16];
  logic [31:0] rz_at  [16];
  logic [31:0] rx_at  [16];
  logic        seen_rsp;

  initial begin
    rst = 1'b1;
    hif1.req_valid = 1'b1; hif1.req_a = '0; hif1.req_b = '0; hif1.req_c = '0; hif1.rsp_ready = 1'b0;
    hif2.req_valid = 1'b0; hif2.req_a = '0; hif2.req_b = '0; hif2.req_c = '0; hif2.rsp_ready = 1'b0;

    // Reset held two cycles with req_valid high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(hif1.req_ready), 64'd1);
    check("rst_rsp_valid", 64'(hif1.rsp_valid), 64'd0);
    check("rst_dut_a", dut_a1, 64'd0);
    check("rst_txn", 64'(txn1), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);

    // Single transaction: a=5, b=-3, c=0x1_0000_0007
    rst = 1'b0;
    hif1.req_a = 64'sd5; hif1.req_b = -64'sd3; hif1.req_c = 64'h1_0000_0007;
    hif1.req_valid = 1'b1; hif1.rsp_ready = 1'b1;
    @(negedge clk);
    check("acc_dut_a", dut_a1, 64'd5);
    check("acc_dut_c", dut_c1, 64'h1_0000_0007);
    check("acc_req_ready", 64'(hif1.req_ready), 64'd0);
    check("acc_busy", 64'(busy1), 64'd1);
    hif1.req_valid = 1'b0;
    @(negedge clk);
    check("lat_rv_1", 64'(hif1.rsp_valid), 64'd0);
    @(negedge clk);
    check("lat_rv_2", 64'(hif1.rsp_valid), 64'd0);
    @(negedge clk);
    check("lat_rv_3", 64'(hif1.rsp_valid), 64'd1);
    check("single_z", 64'(hif1.rsp_z), 64'd2);
    check("single_x", 64'(hif1.rsp_x), 64'd7);
    check("single_txn_pre", 64'(txn1), 64'd0);
    @(negedge clk);
    check("single_rv_drop", 64'(hif1.rsp_valid), 64'd0);
    check("single_txn", 64'(txn1), 64'd1);
    check("single_req_ready", 64'(hif1.req_ready), 64'd1);

    // Backpressure, with a changed req_a presented while busy
    hif1.req_a = 64'sd5; hif1.req_valid = 1'b1; hif1.rsp_ready = 1'b0;
    @(negedge clk);
    hif1.req_a = 64'sd99;
    check("busy_dut_a_0", dut_a1, 64'd5);
    @(negedge clk);
    check("busy_dut_a_1", dut_a1, 64'd5);
    @(negedge clk);
    check("busy_dut_a_2", dut_a1, 64'd5);
    check("busy_rv", 64'(hif1.rsp_valid), 64'd0);
    hif1.req_valid = 1'b0; hif1.req_a = 64'sd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rv", 64'(hif1.rsp_valid), 64'd1);
      check("bp_z", 64'(hif1.rsp_z), 64'd2);
      check("bp_dut_a", dut_a1, 64'd5);
      check("bp_txn", 64'(txn1), 64'd1);
    end
    hif1.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_txn_after", 64'(txn1), 64'd2);
    check("bp_rv_after", 64'(hif1.rsp_valid), 64'd0);

    // Reset asserted in the second WAIT cycle
    hif1.req_valid = 1'b1;
    @(negedge clk);
    hif1.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", 64'(busy1), 64'd0);
    check("mrst_req_ready", 64'(hif1.req_ready), 64'd1);
    check("mrst_rv", 64'(hif1.rsp_valid), 64'd0);
    check("mrst_txn", 64'(txn1), 64'd0);
    check("mrst_dut_a", dut_a1, 64'd0);
    rst = 1'b0;
    seen_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (hif1.rsp_valid) seen_rsp = 1'b1;
    end
    check("mrst_no_rsp", 64'(seen_rsp), 64'd0);

    // Counter wrap and back-to-back on the LATENCY=1 harness
    force u2.txn_count_q = 16'hFFFF;
    #1;
    release u2.txn_count_q;
    @(negedge clk);
    check("wrap_preload", 64'(txn2), 64'hFFFF);
    hif2.req_a = 64'sd10; hif2.req_b = 64'sd20; hif2.req_c = 64'sd3;
    hif2.req_valid = 1'b1; hif2.rsp_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 16 && n_acc < 2; i++) begin
      cnt_at[i] = txn2;
      rv_at[i]  = hif2.rsp_valid;
      rz_at[i]  = hif2.rsp_z;
      rx_at[i]  = hif2.rsp_x;
      if (hif2.req_ready) begin
        acc_cyc[n_acc] = i;
        n_acc++;
      end
      @(negedge clk);
    end
    hif2.req_valid = 1'b0;
    check("b2b_accepts", 64'(n_acc), 64'd2);
    if (n_acc == 2) begin
      check("b2b_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd4);
      check("wrap_cnt_resp", 64'(cnt_at[3]), 64'hFFFF);
      check("wrap_rv_resp", 64'(rv_at[3]), 64'd1);
      check("wrap_z", 64'(rz_at[3]), 64'd30);
      check("wrap_x", 64'(rx_at[3]), 64'd3);
      check("wrap_cnt_zero", 64'(cnt_at[4]), 64'h0000);
    end
    repeat (3) @(negedge clk);
    check("wrap_cnt_one", 64'(txn2), 64'h0001);
    check("wrap_rv_end", 64'(hif2.rsp_valid), 64'd0);
    check("wrap_busy_end", 64'(busy2), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/datapath_harness.md
# datapath_harness

Sequential transaction wrapper on the operand/result side of a generated registered datapath circuit (clk, rst, signed 64-bit operands a/b/c, signed 32-bit results z/x). It accepts one operand set per request over a valid/ready handshake and drives the operands, held stable, into the circuit. After the circuit's fixed pipeline latency it captures the circuit's results and returns them over a second valid/ready handshake. It sits between a host or bench sequencer and any generated circuit, so the same block feeds operands and collects results for every generated netlist.

## Interface
- IN_WIDTH, 64, operand width (signed)
- OUT_WIDTH, 32, result width (signed)
- LATENCY, 2, register stages between circuit operand inputs and result outputs; legal range 1..15
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high; also wired to the driven circuit's rst
- req_valid  in  1  host presents operand set
- req_ready  out  1  harness can accept; high only in IDLE
- req_a, req_b, req_c  in  IN_WIDTH each  signed operands
- dut_a, dut_b, dut_c  out  IN_WIDTH each  registered operands to the circuit
- dut_z, dut_x  in  OUT_WIDTH each  circuit results
- rsp_valid  out  1  captured results available
- rsp_ready  in  1  host accepts results
- rsp_z, rsp_x  out  OUT_WIDTH each  captured results
- busy  out  1  high in any state other than IDLE
- txn_count  out  16  completed response handshakes, wraps 0xFFFF -> 0x0000

## Operation
- States: IDLE, WAIT, RESP.
- IDLE
  - req_ready=1.
  - On req_valid&&req_ready: latch req_a/b/c into dut_a/b/c, load wait_cnt=LATENCY, go to WAIT.
- WAIT
  - req_ready=0; dut_a/b/c held.
  - If wait_cnt!=0: decrement.
  - If wait_cnt==0: register dut_z/dut_x into rsp_z/rsp_x, set rsp_valid=1, go to RESP.
- RESP
  - rsp_valid=1; rsp_z/rsp_x and dut_a/b/c held stable.
  - On rsp_valid&&rsp_ready: clear rsp_valid, increment txn_count, go to IDLE.
  - rsp_valid never drops without a handshake.
- Operands are passed bit-exact; no sign extension or truncation in the harness. The result width matches the circuit's OUT_WIDTH.
- req_valid is ignored outside IDLE; the host must hold it until req_ready.
- rsp_ready asserted outside RESP has no effect.

## Timing
- Reset values: state=IDLE, req_ready=1 from the first cycle after the reset edge, rsp_valid=0, busy=0, dut_a/b/c=0, rsp_z/rsp_x=0, txn_count=0, wait_cnt=0.
- Reset mid-transaction (WAIT or RESP): abort to IDLE at the reset edge. The pending result is discarded and txn_count clears. The circuit is reset by the same edge.
- Request accepted at edge E0: dut_a/b/c are valid after E0, and wait_cnt=LATENCY after E0.
- wait_cnt reaches 0 after edge E0+LATENCY.
- Capture occurs at edge E0+LATENCY+1, which is also when rsp_valid rises. The circuit outputs have been stable for at least one full cycle at capture.
- Request-to-rsp_valid latency is LATENCY+1 cycles.
- If rsp_ready is already high in the first RESP cycle, the handshake completes at edge E0+LATENCY+2 and req_ready=1 in the following cycle.
- Minimum transaction period: LATENCY+3 cycles.
- One transaction in flight; no pipelining of requests.

## Test plan
- Reset: hold rst 2 cycles with req_valid=1 -> req_ready=1, rsp_valid=0, dut_a=0, txn_count=0. No request is accepted while rst=1.
- Single transaction, LATENCY=2, bench circuit model is a 2-stage registered pipe with z=a[31:0]+b[31:0] and x=c[31:0]:
  - Stimulus: a=5, b=-3, c=0x1_0000_0007, rsp_ready=1.
  - Response: rsp_valid rises 3 cycles after acceptance with rsp_z=2 and rsp_x=7; txn_count=1; req_ready returns 1 cycle later.
- Backpressure: same request with rsp_ready=0 for 10 cycles, then 1.
  - rsp_valid stays 1 and rsp_z=2 stays constant all 10 cycles.
  - dut_a stays 5; txn_count increments only at the handshake.
- Busy rejection: change req_a to 99 with req_valid=1 during WAIT -> dut_a stays 5 and rsp_z is unaffected.
- Mid-operation reset: assert rst in the second WAIT cycle -> next cycle state=IDLE, rsp_valid=0, txn_count=0, and no response appears.
- Counter wrap and back-to-back: preload txn_count via 65535 transactions, or force it in the bench, then run 2 consecutive requests with LATENCY=1:
  - txn_count goes 0xFFFF -> 0x0000 -> 0x0001.
  - Request-to-request spacing is exactly 4 cycles.
